instr_fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS pipeline. It holds the PC, issues requests to instruction memory over a req/ack handshake, and presents fetched words to the decode stage (control unit) through a registered valid/stall interface. It applies jump and branch redirects with squash of in-flight fetches, and stops fetching on a HALT instruction.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/fetch_skid_buf.sv | 44 ++++
 rtl/instr_fetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
// Shared MIPS definitions used by the fetch stage and the control unit:
// instruction field positions, the HALT encoding and the fetch-stage state type.
package mips_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 26;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

    localparam logic [5:0] OPC_RTYPE  = 6'h00;
    localparam logic [5:0] FUNCT_HALT = 6'h3F;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // HALT is an R-type word whose funct field carries the HALT code.
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return (instr[OPC_MSB:OPC_LSB] == OPC_RTYPE) &&
               (instr[FUNCT_MSB:FUNCT_LSB] == FUNCT_HALT);
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
`timescale 1ns/1ps
// One-entry skid buffer holding a fetched word and its PC while decode stalls.
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    // Buffer storage; a clear wins so a flush can never leave a stale entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= {INSTR_W{1'b0}};
            pc_q    <= {ADDR_W{1'b0}};
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// MIPS instruction fetch stage: PC, imem req/ack handshake, registered output to
// decode with stall skid, redirect with squash of an in-flight fetch, and HALT.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    output logic               if_valid,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
    logic               squash_q, squash_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic [ADDR_W-1:0]  out_pc4_q, out_pc4_d;

    logic               fetching_s;
    logic               ack_s;
    logic               can_load_s;
    logic               hold_release_s;
    logic               skid_load_s;
    logic               skid_clear_s;
    logic               skid_valid_s;
    logic [INSTR_W-1:0] skid_instr_s;
    logic [ADDR_W-1:0]  skid_pc_s;

    assign fetching_s     = (state_q == ST_FETCH);
    assign ack_s          = fetching_s && imem_ack;
    assign can_load_s     = !out_valid_q || !stall;
    assign hold_release_s = (state_q == ST_HOLD) && !stall && skid_valid_s;

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load_s),
        .clear_i (skid_clear_s),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (skid_valid_s),
        .instr_o (skid_instr_s),
        .pc_o    (skid_pc_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; redirect beats everything, including a pending HALT.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_ack && !squash_q) begin
                        if (!can_load_s) begin
                            state_d = ST_HOLD;
                        end else if (is_halt(imem_rdata)) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_d = (skid_valid_s && is_halt(skid_instr_s)) ? ST_HALT : ST_FETCH;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // FSM outputs; the request is masked while reset is held.
    always_comb begin
        imem_req = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_FETCH: imem_req = rst;
            ST_HOLD:  imem_req = 1'b0;
            ST_HALT:  halted   = 1'b1;
            default:  imem_req = 1'b0;
        endcase
    end

    // Datapath registers: PC, squash bookkeeping and the decode-facing output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            pend_pc_q   <= {ADDR_W{1'b0}};
            squash_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= {INSTR_W{1'b0}};
            out_pc_q    <= {ADDR_W{1'b0}};
            out_pc4_q   <= {ADDR_W{1'b0}};
        end else begin
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            squash_q    <= squash_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_pc4_q   <= out_pc4_d;
        end
    end

    // Datapath next state.
    always_comb begin
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        squash_d     = squash_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        out_valid_d  = (out_valid_q && !stall) ? 1'b0 : out_valid_q;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if (redirect) begin
            out_valid_d  = 1'b0;
            skid_clear_s = 1'b1;
            // An unacked request must keep its address, so park the target.
            if (fetching_s && !imem_ack) begin
                squash_d  = 1'b1;
                pend_pc_d = redirect_pc;
            end else begin
                squash_d = 1'b0;
                pc_d     = redirect_pc;
            end
        end else if (ack_s && squash_q) begin
            pc_d     = pend_pc_q;
            squash_d = 1'b0;
        end else if (ack_s) begin
            pc_d = pc_q + PC_STEP;
            if (can_load_s) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_rdata;
                out_pc_d    = pc_q;
                out_pc4_d   = pc_q + PC_STEP;
            end else begin
                skid_load_s = 1'b1;
            end
        end else if (hold_release_s) begin
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_s;
            out_pc_d     = skid_pc_s;
            out_pc4_d    = skid_pc_s + PC_STEP;
            skid_clear_s = 1'b1;
        end else begin
            pc_d = pc_q;
        end
    end

    assign imem_addr   = pc_q;
    assign if_instr    = out_instr_q;
    assign if_pc       = out_pc_q;
    assign if_pc_plus4 = out_pc4_q;
    assign if_valid    = out_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
// Self-checking bench for instr_fetch_unit: a behavioural memory with random
// latency, random stall/redirect, and a scoreboard of the program-order stream.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        halted;

    int n_tests = 0;
    int n_fail = 0;
    int n_consumed = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    bit          busy = 1'b0;
    logic [31:0] baddr = 32'h0;
    int          cnt = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_valid    (if_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit word_is_halt(input logic [31:0] w);
        return (w[31:26] == 6'h00) && (w[5:0] == 6'h3F);
    endfunction

    // Program image: HALT at 0x20 and at one offset of every 512-byte block.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h20 || a[8:2] == 7'h50) return 32'h0000_003F;
        if (a < 32'h10) return 32'h0000_0021;
        return {6'h23, a[27:2] ^ 26'h2A5_5A5A};
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] r;
        r = $urandom;
        if (r[3:0] == 4'h0) return 32'hFFFF_FFF0;
        return {r[31:2], 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected stream from a start PC: sequential words up to and including a HALT.
    task automatic load_stream(input logic [31:0] t);
        logic [31:0] a;
        exp_t e;
        exp_q.delete();
        a = t;
        for (int i = 0; i < 200; i++) begin
            e.pc = a;
            e.instr = mem_word(a);
            exp_q.push_back(e);
            if (word_is_halt(e.instr)) break;
            a = a + 32'd4;
        end
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect = 1'b1;
        redirect_pc = t;
        load_stream(t);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    // Memory responder: decides ack/rdata for the coming edge.
    task automatic respond();
        if (imem_req) begin
            if (!busy) begin
                busy = 1'b1;
                baddr = imem_addr;
                cnt = $urandom_range(lat_hi, lat_lo);
            end else begin
                check("addr_stable", imem_addr, baddr);
            end
            if (cnt == 0) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
                busy = 1'b0;
            end else begin
                imem_ack = 1'b0;
                imem_rdata = $urandom;
                cnt--;
            end
        end else begin
            busy = 1'b0;
            imem_ack = 1'b0;
            imem_rdata = $urandom;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req", imem_req, 32'h0);
        check("rst_valid", if_valid, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_pc4", if_pc_plus4, 32'h0);
        check("rst_halted", halted, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
    endtask

    task automatic release_reset();
        rst = 1'b1;
        busy = 1'b0;
        imem_ack = 1'b0;
        load_stream(32'h0);
        #1;
        check("first_req", imem_req, 32'h1);
        check("first_addr", imem_addr, 32'h0);
        respond();
    endtask

    task automatic random_run(input int n);
        int hc;
        hc = 0;
        lat_lo = 0;
        lat_hi = 3;
        for (int c = 0; c < n; c++) begin
            cycle();
            respond();
            stall = ($urandom_range(3, 0) == 0);
            if (halted) begin
                hc++;
                check("halt_noreq", imem_req, 32'h0);
                if (hc >= 3) begin
                    do_redirect(rand_target());
                    hc = 0;
                end
            end else begin
                hc = 0;
                if ($urandom_range(19, 0) == 0) do_redirect(rand_target());
            end
        end
    endtask

    // Monitor: a word is consumed at the next edge when valid, not stalled, not flushed.
    always @(negedge clk) begin
        if (rst && if_valid && !stall && !redirect) begin
            n_consumed++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got pc %h instr %h, expected no word", if_pc, if_instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_pc", if_pc, mon_e.pc);
                check("sb_instr", if_instr, mon_e.instr);
                check("sb_pc4", if_pc_plus4, mon_e.pc + 32'd4);
            end
        end
    end

    initial begin
        bit found;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        release_reset();

        // Zero-wait memory: one word per cycle
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check("zw_valid", if_valid, 32'h1);
            check("zw_if_pc", if_pc, 32'(4 * (i - 1)));
            check("zw_addr", imem_addr, 32'(4 * i));
            respond();
        end

        // Stall for three cycles while an ack lands
        cycle();
        respond();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_noreq", imem_req, 32'h0);
            check("hold_if_pc", if_pc, 32'h0000_000C);
            respond();
            if (i == 2) stall = 1'b0;
        end
        cycle();
        check("skid_out_pc", if_pc, 32'h0000_0010);
        check("skid_out_valid", if_valid, 32'h1);
        respond();

        // Redirect with same-cycle ack, then redirect over a slow outstanding fetch
        cycle();
        respond();
        do_redirect(32'h0000_0010);
        lat_lo = 3;
        lat_hi = 3;
        cycle();
        check("redir_ack_addr", imem_addr, 32'h0000_0010);
        respond();
        cycle();
        respond();
        do_redirect(32'h0000_0100);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (imem_addr != 32'h0000_0010) break;
            respond();
        end
        check("post_squash_addr", imem_addr, 32'h0000_0100);
        lat_lo = 0;
        lat_hi = 0;
        respond();
        repeat (2) begin
            cycle();
            respond();
        end

        // HALT at 0x20 and restart by redirect
        do_redirect(32'h0000_0018);
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (halted) begin
                found = 1'b1;
                break;
            end
            respond();
        end
        check("halt_reached", found, 32'h1);
        check("halt_word_valid", if_valid, 32'h1);
        check("halt_word", if_instr, 32'h0000_003F);
        check("halt_pc", if_pc, 32'h0000_0020);
        respond();
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("halt_req", imem_req, 32'h0);
            check("halt_flag", halted, 32'h1);
            check("halt_once", if_valid, 32'h0);
            respond();
        end
        do_redirect(32'h0000_0040);
        cycle();
        check("unhalt_flag", halted, 32'h0);
        check("unhalt_addr", imem_addr, 32'h0000_0040);
        check("unhalt_req", imem_req, 32'h1);
        respond();

        random_run(3000);

        // Reset in the middle of an outstanding request at 0x3C
        stall = 1'b0;
        cycle();
        respond();
        do_redirect(32'h0000_003C);
        lat_lo = 3;
        lat_hi = 3;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            respond();
            if (busy && imem_addr == 32'h0000_003C) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_req_setup", found, 32'h1);
        rst = 1'b0;
        imem_ack = 1'b0;
        busy = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        lat_lo = 0;
        lat_hi = 0;
        release_reset();

        random_run(300);

        check("progress", (n_consumed > 200), 32'h1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
